// File: rtl/enemy_fire_scheduler_pkg.sv
// Shared types and defaults for the enemy fire scheduler slice.
package enemy_fire_pkg;

  // Scheduler operating mode.
  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } fire_state_t;

  localparam int N_REQ_DEFAULT    = 4;
  localparam int N_SLOT_DEFAULT   = 3;
  localparam int COOLDOWN_DEFAULT = 30;
  localparam int COORD_W          = 10;

endpackage

// File: rtl/enemy_fire_scheduler_rr_pick.sv
// Combinational round-robin finder: first set bit of elig at or after ptr, with wrap.
module rr_pick #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  localparam logic [W:0] N_V = (W + 1)'(N);

  logic [N-1:0] rot;
  logic [W-1:0] off_sel;
  logic [W:0]   sum;

  // Rotate the request vector so bit 0 is the candidate at the pointer.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = elig[(int'(ptr) + k) % N];
    end
  end

  // Lowest set bit of the rotated vector wins; scan high to low so the last hit is lowest.
  always_comb begin
    valid   = 1'b0;
    off_sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid   = 1'b1;
        off_sel = k[W-1:0];
      end
    end
  end

  // Undo the rotation: index = (ptr + offset) mod N.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off_sel};
    if (sum >= N_V) begin
      sum = sum - N_V;
    end
    idx = sum[W-1:0];
  end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Shares enemy bullet slots among enemy planes with round-robin arbitration
// and a per-plane refire cooldown counted in frames.
module enemy_fire_scheduler
  import enemy_fire_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEFAULT,
  parameter int N_SLOT   = N_SLOT_DEFAULT,
  parameter int COOLDOWN = COOLDOWN_DEFAULT,
  parameter int CW       = 6
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_clk,
  input  logic                      enable,
  input  logic [N_REQ-1:0]          launch_req,
  input  logic [N_REQ*COORD_W-1:0]  req_x,
  input  logic [N_REQ*COORD_W-1:0]  req_y,
  input  logic [N_SLOT-1:0]         slot_done,
  output logic [N_REQ-1:0]          launch_grant,
  output logic [N_SLOT-1:0]         slot_fire,
  output logic [N_SLOT*COORD_W-1:0] slot_x,
  output logic [N_SLOT*COORD_W-1:0] slot_y,
  output logic [N_SLOT-1:0]         slot_busy,
  output logic                      busy_all
);

  localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;

  fire_state_t          state_reg, state_next;
  logic                 arb_en;
  logic                 frame_cur_reg, frame_prev_reg, tick;
  logic [RW-1:0]        rr_ptr_reg;
  logic [CW-1:0]        cooldown_reg [N_REQ];
  logic [COORD_W-1:0]   req_x_arr [N_REQ];
  logic [COORD_W-1:0]   req_y_arr [N_REQ];
  logic [COORD_W-1:0]   slot_x_reg [N_SLOT];
  logic [COORD_W-1:0]   slot_y_reg [N_SLOT];
  logic [N_REQ-1:0]     launch_grant_reg;
  logic [N_SLOT-1:0]    slot_fire_reg, slot_busy_reg;
  logic [N_REQ-1:0]     eligible;
  logic                 req_valid, slot_valid, grant_go;
  logic [RW-1:0]        win_idx;
  logic [SW-1:0]        slot_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_x_arr[gi] = req_x[gi*COORD_W +: COORD_W];
      assign req_y_arr[gi] = req_y[gi*COORD_W +: COORD_W];
      assign eligible[gi]  = launch_req[gi] && (cooldown_reg[gi] == '0);
    end
    for (gi = 0; gi < N_SLOT; gi++) begin : g_slot
      assign slot_x[gi*COORD_W +: COORD_W] = slot_x_reg[gi];
      assign slot_y[gi*COORD_W +: COORD_W] = slot_y_reg[gi];
    end
  endgenerate

  rr_pick #(.N(N_REQ)) u_req_pick (
    .elig  (eligible),
    .ptr   (rr_ptr_reg),
    .valid (req_valid),
    .idx   (win_idx)
  );

  // Slot choice reuses the same finder with the pointer pinned to 0 (lowest free slot).
  rr_pick #(.N(N_SLOT)) u_slot_pick (
    .elig  (~slot_busy_reg),
    .ptr   ('0),
    .valid (slot_valid),
    .idx   (slot_idx)
  );

  assign tick     = frame_cur_reg & ~frame_prev_reg;
  assign grant_go = arb_en && req_valid && slot_valid;

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state_reg <= OFF;
    else          state_reg <= state_next;
  end

  // FSM next-state: DRAIN waits for every live bullet to retire before going OFF.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OFF:     if (enable) state_next = ACTIVE;
      ACTIVE:  if (!enable) state_next = DRAIN;
      DRAIN:   if (enable) state_next = ACTIVE;
               else if (slot_busy_reg == '0) state_next = OFF;
      default: state_next = OFF;
    endcase
  end

  // FSM output: arbitration only runs while ACTIVE.
  always_comb begin
    arb_en = (state_reg == ACTIVE);
  end

  // Frame clock synchroniser/edge detector and round-robin pointer.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      frame_cur_reg  <= 1'b0;
      frame_prev_reg <= 1'b0;
      rr_ptr_reg     <= '0;
    end else begin
      frame_cur_reg  <= frame_clk;
      frame_prev_reg <= frame_cur_reg;
      if (grant_go) begin
        rr_ptr_reg <= (win_idx == RW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // Cooldowns: a grant reload beats a same-cycle frame decrement for the winner.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (!Reset_n) begin
        cooldown_reg[i] <= '0;
      end else if (grant_go && win_idx == RW'(i)) begin
        cooldown_reg[i] <= CW'(COOLDOWN);
      end else if (tick && cooldown_reg[i] != '0) begin
        cooldown_reg[i] <= cooldown_reg[i] - 1'b1;
      end
    end
  end

  // Grant/fire strobes, slot ownership and latched start coordinates.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      launch_grant_reg <= '0;
      slot_fire_reg    <= '0;
      slot_busy_reg    <= '0;
      for (int k = 0; k < N_SLOT; k++) begin
        slot_x_reg[k] <= '0;
        slot_y_reg[k] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        launch_grant_reg[i] <= grant_go && (win_idx == RW'(i));
      end
      for (int k = 0; k < N_SLOT; k++) begin
        slot_fire_reg[k] <= grant_go && (slot_idx == SW'(k));
        if (grant_go && slot_idx == SW'(k)) begin
          slot_busy_reg[k] <= 1'b1;
          slot_x_reg[k]    <= req_x_arr[win_idx];
          slot_y_reg[k]    <= req_y_arr[win_idx];
        end else if (slot_done[k]) begin
          slot_busy_reg[k] <= 1'b0;
        end
      end
    end
  end

  assign launch_grant = launch_grant_reg;
  assign slot_fire    = slot_fire_reg;
  assign slot_busy    = slot_busy_reg;
  assign busy_all     = &slot_busy_reg;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Self-checking bench for enemy_fire_scheduler: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_enemy_fire_scheduler;

  localparam int NR = 4;
  localparam int NS = 3;
  localparam int CD = 30;
  localparam int M_OFF = 0, M_ACTIVE = 1, M_DRAIN = 2;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              frame_clk = 1'b0;
  logic              enable = 1'b0;
  logic [NR-1:0]     launch_req = '0;
  logic [NR*10-1:0]  req_x = '0;
  logic [NR*10-1:0]  req_y = '0;
  logic [NS-1:0]     slot_done = '0;
  logic [NR-1:0]     launch_grant;
  logic [NS-1:0]     slot_fire;
  logic [NS*10-1:0]  slot_x;
  logic [NS*10-1:0]  slot_y;
  logic [NS-1:0]     slot_busy;
  logic              busy_all;

  int checks = 0;
  int failures = 0;
  bit check_en = 0;

  // Model state (what the outputs must be now) and its next values.
  int m_cd[NR], n_cd[NR];
  int m_ptr, n_ptr, m_mode, n_mode;
  bit m_f1, m_f2, n_f1, n_f2;
  bit [NR-1:0] m_grant, n_grant;
  bit [NS-1:0] m_fire, n_fire, m_busy, n_busy;
  int m_sx[NS], m_sy[NS], n_sx[NS], n_sy[NS];

  enemy_fire_scheduler #(.N_REQ(NR), .N_SLOT(NS), .COOLDOWN(CD), .CW(6)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .enable       (enable),
    .launch_req   (launch_req),
    .req_x        (req_x),
    .req_y        (req_y),
    .slot_done    (slot_done),
    .launch_grant (launch_grant),
    .slot_fire    (slot_fire),
    .slot_x       (slot_x),
    .slot_y       (slot_y),
    .slot_busy    (slot_busy),
    .busy_all     (busy_all)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Rules applied to the inputs present at the coming clock edge.
  task automatic model_next();
    int win, slt;
    bit tick, go;
    if (!Reset_n) begin
      n_mode = M_OFF; n_ptr = 0; n_f1 = 0; n_f2 = 0;
      n_grant = '0; n_fire = '0; n_busy = '0;
      for (int i = 0; i < NR; i++) n_cd[i] = 0;
      for (int k = 0; k < NS; k++) begin n_sx[k] = 0; n_sy[k] = 0; end
      return;
    end
    tick = m_f1 && !m_f2;
    n_f1 = frame_clk;
    n_f2 = m_f1;
    win = -1;
    if (m_mode == M_ACTIVE) begin
      for (int off = 0; off < NR; off++) begin
        int i;
        i = (m_ptr + off) % NR;
        if (win < 0 && launch_req[i] && m_cd[i] == 0) win = i;
      end
    end
    slt = -1;
    for (int k = 0; k < NS; k++) if (slt < 0 && !m_busy[k]) slt = k;
    go = (win >= 0) && (slt >= 0);
    n_grant = '0;
    n_fire = '0;
    for (int i = 0; i < NR; i++) begin
      if (go && i == win)           n_cd[i] = CD;
      else if (tick && m_cd[i] > 0) n_cd[i] = m_cd[i] - 1;
      else                          n_cd[i] = m_cd[i];
    end
    for (int k = 0; k < NS; k++) begin
      n_sx[k] = m_sx[k];
      n_sy[k] = m_sy[k];
      if (go && k == slt) begin
        n_busy[k] = 1'b1;
        n_sx[k] = int'(req_x[win*10 +: 10]);
        n_sy[k] = int'(req_y[win*10 +: 10]);
      end else if (slot_done[k]) begin
        n_busy[k] = 1'b0;
      end else begin
        n_busy[k] = m_busy[k];
      end
    end
    if (go) begin
      n_grant[win] = 1'b1;
      n_fire[slt] = 1'b1;
      n_ptr = (win + 1) % NR;
    end else begin
      n_ptr = m_ptr;
    end
    n_mode = m_mode;
    if (m_mode == M_OFF && enable) n_mode = M_ACTIVE;
    else if (m_mode == M_ACTIVE && !enable) n_mode = M_DRAIN;
    else if (m_mode == M_DRAIN) begin
      if (enable) n_mode = M_ACTIVE;
      else if (m_busy == '0) n_mode = M_OFF;
    end
  endtask

  task automatic model_commit();
    m_cd = n_cd; m_ptr = n_ptr; m_mode = n_mode; m_f1 = n_f1; m_f2 = n_f2;
    m_grant = n_grant; m_fire = n_fire; m_busy = n_busy; m_sx = n_sx; m_sy = n_sy;
  endtask

  // One clock: model sees the same inputs as the DUT, then return just after the falling edge.
  task automatic step();
    model_next();
    @(posedge Clk);
    model_commit();
    @(negedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 0; enable = 0; launch_req = '0; slot_done = '0; frame_clk = 0;
    step();
    step();
    Reset_n = 1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge Clk) begin
    if (check_en) begin
      logic [NS*10-1:0] ex, ey;
      for (int k = 0; k < NS; k++) begin
        ex[k*10 +: 10] = 10'(m_sx[k]);
        ey[k*10 +: 10] = 10'(m_sy[k]);
      end
      chk("model_grant", 64'(launch_grant), 64'(m_grant));
      chk("model_fire", 64'(slot_fire), 64'(m_fire));
      chk("model_busy", 64'(slot_busy), 64'(m_busy));
      chk("model_busy_all", 64'(busy_all), 64'(&m_busy));
      chk("model_slot_x", 64'(slot_x), 64'(ex));
      chk("model_slot_y", 64'(slot_y), 64'(ey));
    end
  end

  initial begin
    int gcount;
    Reset_n = 0;
    step();
    check_en = 1;
    do_reset();

    // Single request latches coordinates into slot 0.
    chk("rst_grant", 64'(launch_grant), 64'h0);
    chk("rst_busy", 64'(slot_busy), 64'h0);
    chk("rst_slot_x", 64'(slot_x), 64'h0);
    enable = 1; launch_req = 4'b0001; req_x[9:0] = 10'd300; req_y[9:0] = 10'd40;
    step();
    chk("t1_off_no_grant", 64'(launch_grant), 64'h0);
    step();
    chk("t1_grant", 64'(launch_grant), 64'h1);
    chk("t1_fire", 64'(slot_fire), 64'h1);
    chk("t1_x0", 64'(slot_x[9:0]), 64'd300);
    chk("t1_y0", 64'(slot_y[9:0]), 64'd40);
    launch_req = '0;
    step();
    chk("t1_pulse_end", 64'(launch_grant), 64'h0);
    chk("t1_busy", 64'(slot_busy), 64'h1);

    // All planes request: three slots fill, plane 3 waits for a release.
    do_reset();
    enable = 1; launch_req = 4'b1111;
    step();
    step(); chk("t2_g0", 64'({launch_grant, slot_fire}), 64'({4'b0001, 3'b001}));
    step(); chk("t2_g1", 64'({launch_grant, slot_fire}), 64'({4'b0010, 3'b010}));
    step(); chk("t2_g2", 64'({launch_grant, slot_fire}), 64'({4'b0100, 3'b100}));
    step(); chk("t2_wait", 64'({launch_grant, busy_all}), 64'({4'b0000, 1'b1}));
    slot_done = 3'b010;
    step(); chk("t2_release_no_reuse", 64'({launch_grant, slot_busy}), 64'({4'b0000, 3'b101}));
    slot_done = '0;
    step(); chk("t2_g3", 64'({launch_grant, slot_fire}), 64'({4'b1000, 3'b010}));

    // Reset_n glitch between edges is ignored.
    Reset_n = 0; #2; Reset_n = 1;
    step(); chk("t6_glitch", 64'(slot_busy), 64'h7);

    // Reset with a grant decision pending drops it.
    do_reset();
    enable = 1; launch_req = 4'b0111;
    step(); step(); step();
    Reset_n = 0;
    step();
    chk("t6_reset_outs", 64'({launch_grant, slot_fire, slot_busy}), 64'h0);
    Reset_n = 1; launch_req = 4'b0001;
    step(); chk("t6_off_after_reset", 64'(launch_grant), 64'h0);
    step(); chk("t6_resume", 64'(launch_grant), 64'h1);

    // Cooldown: tick during the grant cycle must not shorten the 30-frame wait.
    do_reset();
    enable = 1; launch_req = 4'b0001; frame_clk = 1;
    step();
    frame_clk = 0;
    step(); chk("t3_first", 64'(launch_grant), 64'h1);
    gcount = 0;
    for (int n = 0; n < 29; n++) begin
      frame_clk = 1; step(); gcount += int'(launch_grant != 0);
      frame_clk = 0; step(); gcount += int'(launch_grant != 0);
    end
    chk("t3_no_early_grant", 64'(gcount), 64'd0);
    frame_clk = 1; step();
    frame_clk = 0; step(); chk("t3_tick30_cycle", 64'(launch_grant), 64'h0);
    step(); chk("t3_regrant", 64'({launch_grant, slot_fire}), 64'({4'b0001, 3'b010}));

    // Drain: no grants until slots retire, then OFF, then resume.
    do_reset();
    enable = 1; launch_req = 4'b0011;
    step(); step(); step();
    enable = 0;
    step();
    launch_req = 4'b1111;
    gcount = 0;
    step(); gcount += int'(launch_grant != 0);
    step(); gcount += int'(launch_grant != 0);
    slot_done = 3'b011;
    step(); gcount += int'(launch_grant != 0);
    slot_done = '0;
    step(); gcount += int'(launch_grant != 0);
    step(); gcount += int'(launch_grant != 0);
    chk("t5_drain_no_grant", 64'(gcount), 64'd0);
    enable = 1;
    step(); chk("t5_off_first", 64'(launch_grant), 64'h0);
    step(); chk("t5_resume", 64'(launch_grant), 64'h4);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      Reset_n    = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      launch_req = 4'($urandom_range(0, 15));
      slot_done  = '0;
      for (int k = 0; k < NS; k++) slot_done[k] = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NR; i++) begin
        req_x[i*10 +: 10] = 10'($urandom_range(0, 1023));
        req_y[i*10 +: 10] = 10'($urandom_range(0, 1023));
      end
      step();
    end

    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
